// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: drives a shared 16-bit add/multiply ALU to produce one FIR
// output per accepted sample. Each tap is one multiply cycle and then one accumulate cycle.
// Optional build macro: FIR_SAT_EN. When defined, the accumulator saturates at 16'hFFFF
// on the first carry-out and keeps that value for the rest of the sample. When it is not
// defined, the accumulator wraps modulo 2**16.
module fir_mac_sequencer #(
    parameter int unsigned TAPS = 4,
    parameter int unsigned CAW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     din,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic           coef_wr,
    input  logic [CAW-1:0] coef_addr,
    input  logic [7:0]     coef_data,
    output logic [15:0]    alu_a,
    output logic [15:0]    alu_b,
    output logic           alu_addb,
    output logic           alu_mulb,
    output logic           alu_cin,
    input  logic [15:0]    alu_out,
    input  logic           alu_cout,
    input  logic           alu_zout,
    output logic [15:0]    dout,
    output logic           dout_valid,
    output logic           dout_ovf,
    output logic           dout_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;

    localparam logic [CAW-1:0] K_LAST = CAW'(TAPS - 1);
    localparam logic [CAW:0]   TAPS_W = TAPS[CAW:0];

    state_t         state_q;
    logic [CAW-1:0] k_q;
    logic [CAW-1:0] k_d;
    logic [7:0]     x_q [TAPS];
    logic [7:0]     c_q [TAPS];
    logic [15:0]    acc_q;
    logic [15:0]    acc_d;
    logic           ovf_q;
    logic           ovf_d;
    logic           zero_q;
    logic [15:0]    dout_q;
    logic           dout_valid_q;
    logic           dout_ovf_q;
    logic           dout_zero_q;
    logic [15:0]    alu_a_q;
    logic [15:0]    alu_b_q;
    logic           alu_addb_q;
    logic           alu_mulb_q;

    // Next-tap index and the accumulate result, which may saturate
    always_comb begin
        k_d   = k_q + CAW'(1);
        ovf_d = ovf_q | alu_cout;
`ifdef FIR_SAT_EN
        acc_d = ovf_d ? '1 : alu_out;
`else
        acc_d = alu_out;
`endif
    end

    // Sequencer FSM. ALU controls are registered, so each one is loaded for the state being entered.
    // alu_b_q also serves as the product register: in MUL it captures alu_out for the following ADD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_ovf_q   <= 1'b0;
            dout_zero_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_addb_q   <= 1'b0;
            alu_mulb_q   <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (coef_wr && ({1'b0, coef_addr} < TAPS_W))
                        c_q[coef_addr] <= coef_data;
                    if (din_valid) begin
                        for (int unsigned i = 1; i < TAPS; i++)
                            x_q[i] <= x_q[i-1];
                        x_q[0]     <= din;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        k_q        <= '0;
                        alu_a_q    <= {8'h00, din};
                        alu_b_q    <= {8'h00, c_q[0]};
                        alu_mulb_q <= 1'b1;
                        state_q    <= S_MUL;
                    end
                end
                S_MUL: begin
                    alu_mulb_q <= 1'b0;
                    alu_addb_q <= 1'b1;
                    alu_a_q    <= acc_q;
                    alu_b_q    <= alu_out;
                    state_q    <= S_ADD;
                end
                S_ADD: begin
                    acc_q      <= acc_d;
                    ovf_q      <= ovf_d;
                    zero_q     <= alu_zout;
                    alu_addb_q <= 1'b0;
                    if (k_q == K_LAST) begin
                        alu_a_q <= '0;
                        alu_b_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        k_q        <= k_d;
                        alu_mulb_q <= 1'b1;
                        alu_a_q    <= {8'h00, x_q[k_d]};
                        alu_b_q    <= {8'h00, c_q[k_d]};
                        state_q    <= S_MUL;
                    end
                end
                S_DONE: begin
                    dout_q       <= acc_q;
                    dout_ovf_q   <= ovf_q;
                    dout_zero_q  <= zero_q;
                    dout_valid_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign din_ready  = (state_q == S_IDLE) && !reset;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_addb   = alu_addb_q;
    assign alu_mulb   = alu_mulb_q;
    assign alu_cin    = 1'b0;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_ovf   = dout_ovf_q;
    assign dout_zero  = dout_zero_q;

endmodule
